// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register. Captures decoded ID fields for EX, inserts load-use
// bubbles, squashes on branch flush, holds on EX stall, and keeps saturating
// counters of bubbles and flushes.
module id_exe_stage_reg #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALU_OP_W       = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [XLEN-1:0]           id_rs1_data,
  input  logic [XLEN-1:0]           id_rs2_data,
  input  logic [XLEN-1:0]           id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_wen,
  input  logic                      id_mem_ren,
  input  logic                      id_mem_wen,
  input  logic [ALU_OP_W-1:0]       id_alu_op,
  input  logic [1:0]                id_wb_sel,
  input  logic                      hazard_clear_ctr,
  input  logic                      flush,
  input  logic                      exe_stall,
  output logic                      ex_valid,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [ALU_OP_W-1:0]       ex_alu_op,
  output logic [1:0]                ex_wb_sel,
  output logic                      ex_reg_wen,
  output logic                      ex_mem_wen,
  output logic                      id_exe_reg_mem_ren,
  output logic [REG_ADDR_WIDTH-1:0] id_exe_reg_waddr,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic                      valid_q, valid_d;
  logic [XLEN-1:0]           pc_q, pc_d, rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]           rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, waddr_q, waddr_d;
  logic [ALU_OP_W-1:0]       alu_op_q, alu_op_d;
  logic [1:0]                wb_sel_q, wb_sel_d;
  logic                      reg_wen_q, reg_wen_d, mem_ren_q, mem_ren_d;
  logic                      mem_wen_q, mem_wen_d;
  logic [CNT_W-1:0]          bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                      do_squash, do_bubble, do_load;

  // Decode the single action for this edge: stall > flush > hazard > load.
  always_comb begin
    do_squash = !exe_stall && flush;
    do_bubble = !exe_stall && !flush && hazard_clear_ctr;
    do_load   = !exe_stall && !flush && !hazard_clear_ctr;
  end

  // Next-state for the pipeline fields; bubbles zero everything so the hazard
  // detector sees waddr=0 / mem_ren=0 and cannot re-trigger.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    waddr_d    = waddr_q;
    alu_op_d   = alu_op_q;
    wb_sel_d   = wb_sel_q;
    reg_wen_d  = reg_wen_q;
    mem_ren_d  = mem_ren_q;
    mem_wen_d  = mem_wen_q;
    if (do_squash || do_bubble) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      waddr_d    = '0;
      alu_op_d   = '0;
      wb_sel_d   = '0;
      reg_wen_d  = 1'b0;
      mem_ren_d  = 1'b0;
      mem_wen_d  = 1'b0;
    end else if (do_load) begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      waddr_d    = id_rd;
      alu_op_d   = id_alu_op;
      wb_sel_d   = id_wb_sel;
      // An invalid slot must never write architectural state.
      reg_wen_d  = id_valid && id_reg_wen;
      mem_ren_d  = id_valid && id_mem_ren;
      mem_wen_d  = id_valid && id_mem_wen;
    end
  end

  // Saturating event counters.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (do_bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    if (do_squash && (flush_cnt_q != '1))  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      waddr_q      <= '0;
      alu_op_q     <= '0;
      wb_sel_q     <= '0;
      reg_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      waddr_q      <= waddr_d;
      alu_op_q     <= alu_op_d;
      wb_sel_q     <= wb_sel_d;
      reg_wen_q    <= reg_wen_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid           = valid_q;
  assign ex_pc              = pc_q;
  assign ex_rs1_data        = rs1_data_q;
  assign ex_rs2_data        = rs2_data_q;
  assign ex_imm             = imm_q;
  assign ex_rs1             = rs1_q;
  assign ex_rs2             = rs2_q;
  assign ex_alu_op          = alu_op_q;
  assign ex_wb_sel          = wb_sel_q;
  assign ex_reg_wen         = reg_wen_q;
  assign ex_mem_wen         = mem_wen_q;
  assign id_exe_reg_mem_ren = mem_ren_q;
  assign id_exe_reg_waddr   = waddr_q;
  assign bubble_cnt         = bubble_cnt_q;
  assign flush_cnt          = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: a 32-bit-counter instance and a
// 4-bit-counter instance share stimulus; expected values come from a
// behavioural model and are checked by a separate monitor.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, waddr;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        reg_wen, mem_ren, mem_wen;
  } fld_t;

  typedef struct packed {
    fld_t        f;
    logic [31:0] bcnt, fcnt;
    logic [3:0]  bcnt4, fcnt4;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_reg_wen, id_mem_ren, id_mem_wen;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_alu_op;
  logic [1:0] id_wb_sel;
  logic hazard_clear_ctr, flush, exe_stall;

  logic        ex_valid, ex_reg_wen, ex_mem_wen, mem_ren_o;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, bubble_cnt, flush_cnt;
  logic [4:0]  ex_rs1, ex_rs2, waddr_o;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_wb_sel;

  logic        s_valid, s_reg_wen, s_mem_wen, s_mem_ren;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_waddr;
  logic [3:0]  s_alu_op, s_bcnt, s_fcnt;
  logic [1:0]  s_wb_sel;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t m;
  exp_t q[$];

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen), .id_alu_op(id_alu_op),
    .id_wb_sel(id_wb_sel), .hazard_clear_ctr(hazard_clear_ctr), .flush(flush),
    .exe_stall(exe_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_op(ex_alu_op), .ex_wb_sel(ex_wb_sel),
    .ex_reg_wen(ex_reg_wen), .ex_mem_wen(ex_mem_wen), .id_exe_reg_mem_ren(mem_ren_o),
    .id_exe_reg_waddr(waddr_o), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_stage_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_wen(id_reg_wen),
    .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen), .id_alu_op(id_alu_op),
    .id_wb_sel(id_wb_sel), .hazard_clear_ctr(hazard_clear_ctr), .flush(flush),
    .exe_stall(exe_stall), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_alu_op(s_alu_op), .ex_wb_sel(s_wb_sel),
    .ex_reg_wen(s_reg_wen), .ex_mem_wen(s_mem_wen), .id_exe_reg_mem_ren(s_mem_ren),
    .id_exe_reg_waddr(s_waddr), .bubble_cnt(s_bcnt), .flush_cnt(s_fcnt)
  );

  // Protocol rule: EX never redirects while it is stalled.
  always @(posedge clk) if (rst_n) assert (!(exe_stall && flush));

  function automatic fld_t act_main();
    return '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, waddr_o,
             ex_alu_op, ex_wb_sel, ex_reg_wen, mem_ren_o, ex_mem_wen};
  endfunction

  function automatic fld_t act_sat();
    return '{s_valid, s_pc, s_rs1_data, s_rs2_data, s_imm, s_rs1, s_rs2, s_waddr,
             s_alu_op, s_wb_sel, s_reg_wen, s_mem_ren, s_mem_wen};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("fields", 256'(act_main()), 256'(e.f));
        check("fields_cnt4", 256'(act_sat()), 256'(e.f));
        check("counters", 256'({bubble_cnt, flush_cnt}), 256'({e.bcnt, e.fcnt}));
        check("counters4", 256'({s_bcnt, s_fcnt}), 256'({e.bcnt4, e.fcnt4}));
      end
    end
  end

  task automatic rand_inputs();
    id_valid    = ($urandom_range(3) != 0);
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_rs1      = 5'($urandom);
    id_rs2      = 5'($urandom);
    id_rd       = 5'($urandom);
    id_reg_wen  = 1'($urandom);
    id_mem_ren  = 1'($urandom);
    id_mem_wen  = 1'($urandom);
    id_alu_op   = 4'($urandom);
    id_wb_sel   = 2'($urandom);
    hazard_clear_ctr = 1'b0;
    flush       = 1'b0;
    exe_stall   = 1'b0;
  endtask

  // Apply current inputs at a negedge, predict the next edge, then advance.
  task automatic step();
    if (exe_stall) begin
      // hold
    end else if (flush || hazard_clear_ctr) begin
      m.f = '0;
      if (flush) begin
        if (m.fcnt != 32'hFFFF_FFFF) m.fcnt = m.fcnt + 1;
        if (m.fcnt4 != 4'd15) m.fcnt4 = m.fcnt4 + 1;
      end else begin
        if (m.bcnt != 32'hFFFF_FFFF) m.bcnt = m.bcnt + 1;
        if (m.bcnt4 != 4'd15) m.bcnt4 = m.bcnt4 + 1;
      end
    end else begin
      m.f = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
              id_alu_op, id_wb_sel, id_valid & id_reg_wen, id_valid & id_mem_ren,
              id_valid & id_mem_wen};
    end
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic stall_at_release);
    @(posedge clk);
    #2;
    rand_inputs();
    rst_n = 1'b0;
    #1;
    check("async_reset", 256'({act_main(), bubble_cnt, flush_cnt}), 256'(0));
    check("async_reset4", 256'({act_sat(), s_bcnt, s_fcnt}), 256'(0));
    m = '0;
    @(negedge clk);
    exe_stall = stall_at_release;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0;
    rand_inputs();
    #1;
    check("reset_init", 256'({act_main(), bubble_cnt, flush_cnt}), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain load of a valid load instruction.
    rand_inputs(); id_valid = 1; id_pc = 32'h8000_0004; id_rd = 5'd5; id_mem_ren = 1; step();
    // Load-use bubble, then the held instruction loads.
    rand_inputs(); id_rd = 5'd7; id_valid = 1; id_mem_ren = 1; hazard_clear_ctr = 1; step();
    rand_inputs(); id_rd = 5'd7; id_valid = 1; step();
    // Flush and hazard together: squash only.
    rand_inputs(); flush = 1; hazard_clear_ctr = 1; step();
    // Stall hold against a pending hazard request.
    rand_inputs(); id_valid = 1; id_pc = 32'h100; step();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); id_pc = 32'h200; exe_stall = 1; hazard_clear_ctr = 1; step();
    end
    rand_inputs(); id_valid = 1; id_pc = 32'h200; step();
    // Invalid slot never writes state.
    rand_inputs(); id_valid = 0; id_reg_wen = 1; id_mem_ren = 1; id_mem_wen = 1; step();
    // Back-to-back bubbles drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      rand_inputs(); hazard_clear_ctr = 1; step();
    end
    for (int i = 0; i < 18; i++) begin
      rand_inputs(); flush = 1; step();
    end

    // Asynchronous reset mid-cycle, released while stalled.
    do_reset(1'b1);
    rand_inputs(); exe_stall = 1; step();
    rand_inputs(); id_valid = 1; step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      exe_stall        = ($urandom_range(4) == 0);
      flush            = !exe_stall && ($urandom_range(7) == 0);
      hazard_clear_ctr = ($urandom_range(3) == 0);
      step();
    end

    do_reset(1'b0);
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      exe_stall        = ($urandom_range(4) == 0);
      flush            = !exe_stall && ($urandom_range(5) == 0);
      hazard_clear_ctr = ($urandom_range(2) == 0);
      step();
    end

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage NPC core, and the responder to the load-use hazard detector.
- Captures decoded ID-stage fields each cycle and presents them to EX.
- Inserts a bubble when the hazard detector asserts hazard_clear_ctr, and squashes the entry on a branch flush.
- Feeds id_exe_reg_mem_ren / id_exe_reg_waddr back to the hazard detector; keeps saturating counters of inserted bubbles and flushes.

Parameters:
XLEN, 32, datapath width (pc, operands, immediate)
REG_ADDR_WIDTH, 5, register index width (matches `REG_ADDR_WIDTH)
ALU_OP_W, 4, ALU opcode width
CNT_W, 32, performance counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID slot holds a real instruction
id_pc  input  XLEN  instruction PC
id_rs1_data  input  XLEN  rs1 operand
id_rs2_data  input  XLEN  rs2 operand
id_imm  input  XLEN  immediate
id_rs1  input  REG_ADDR_WIDTH  rs1 index (passed to forwarding)
id_rs2  input  REG_ADDR_WIDTH  rs2 index
id_rd  input  REG_ADDR_WIDTH  destination index
id_reg_wen  input  1  register write enable
id_mem_ren  input  1  load
id_mem_wen  input  1  store
id_alu_op  input  ALU_OP_W  ALU operation
id_wb_sel  input  2  writeback source select
hazard_clear_ctr  input  1  load-use bubble request from hazard detector
flush  input  1  branch/jump redirect from EX; squash incoming entry
exe_stall  input  1  EX/MEM busy; hold register contents
ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_alu_op, ex_wb_sel, ex_reg_wen, ex_mem_wen  output  (widths as matching id_*)  registered EX-stage fields
id_exe_reg_mem_ren  output  1  registered load flag (to hazard detector)
id_exe_reg_waddr  output  REG_ADDR_WIDTH  registered rd (to hazard detector)
bubble_cnt  output  CNT_W  load-use bubbles inserted, saturating
flush_cnt  output  CNT_W  flush squashes performed, saturating

Behaviour:
- Reset (rst_n low, asynchronous, any cycle): every output goes to 0 immediately (valid, all control, all data, both counters). It stays 0 until the first rising edge after rst_n deasserts.
- Each rising edge applies exactly one action, in priority order:
  1. exe_stall=1 -> HOLD: all registered fields keep their value. flush and hazard_clear_ctr are ignored. Counters do not change.
  2. flush=1 -> SQUASH: load a bubble. flush_cnt += 1.
  3. hazard_clear_ctr=1 -> BUBBLE: load a bubble. bubble_cnt += 1.
  4. Otherwise -> LOAD: capture all id_* fields.
- LOAD with id_valid=0 captures the fields as-is, but ex_reg_wen, ex_mem_wen and id_exe_reg_mem_ren are forced to 0. An invalid slot never writes state.
- Bubble: all outputs are 0, i.e. ex_valid=0, reg_wen=0, mem_ren=0, mem_wen=0, waddr=0, data fields=0, alu_op=0, wb_sel=0. Because waddr=0 and mem_ren=0, the hazard detector cannot re-trigger on a bubble.
- Latency: 1 cycle from id_* to ex_*. No combinational path from any input to any output.
- Counters:
  - increment by 1 per qualifying edge; both can never increment in the same cycle (flush wins);
  - saturate at 2^CNT_W-1 with no wrap;
  - cleared only by reset.
- Simultaneous flush and hazard_clear_ctr: SQUASH; only flush_cnt increments.
- Simultaneous exe_stall and flush: HOLD. The EX generator must not assert flush while stalled; the bench asserts this as a protocol rule but the RTL still gives HOLD.
- Back-to-back hazard_clear_ctr on consecutive edges: one bubble per edge; bubble_cnt increments each edge.
- Reset released mid-stall: the first post-reset edge follows the normal priority rules; no residual HOLD state.

Test Plan:
- Reset: drive random id_*, assert rst_n=0 mid-cycle -> all outputs 0 immediately, before the next edge; counters 0.
- Plain load: id_valid=1, id_pc=0x80000004, id_rd=5, id_mem_ren=1 -> next edge: ex_pc=0x80000004, id_exe_reg_waddr=5, id_exe_reg_mem_ren=1, ex_valid=1.
- Load-use bubble: hazard_clear_ctr=1 for one edge with id_rd=7 -> ex_valid=0, id_exe_reg_waddr=0, id_exe_reg_mem_ren=0, bubble_cnt=1. The next edge with clear=0 loads id_rd=7.
- Flush plus hazard: flush=1, hazard_clear_ctr=1 on the same edge -> bubble outputs, flush_cnt=1, bubble_cnt unchanged at 0.
- Stall hold: load pc=0x100, then exe_stall=1 for 3 edges with id_pc=0x200 and hazard_clear_ctr=1 -> ex_pc stays 0x100, bubble_cnt stays 0. The edge after stall drops loads 0x200 (or a bubble if clear is still high).
- Saturation: CNT_W=4, 20 consecutive hazard_clear_ctr edges -> bubble_cnt=15 and stays 15; invalid-slot load (id_valid=0, id_reg_wen=1) -> ex_reg_wen=0.
